// File: rtl/seq_signed_divider.sv
// Sequential signed divider: restoring division on operand magnitudes, one quotient
// bit per cycle, followed by a one-cycle sign fix-up. Truncating (C-style) semantics.
module seq_signed_divider #(
  parameter int WORD_LEN = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [WORD_LEN-1:0] i_dividend,
  input  logic [WORD_LEN-1:0] i_divisor,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [WORD_LEN-1:0] o_quotient,
  output logic [WORD_LEN-1:0] o_remainder,
  output logic                o_div_by_zero,
  output logic                o_overflow
);

  localparam int CW = $clog2(WORD_LEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       count;
  logic [WORD_LEN-1:0] dividend_q;
  logic [WORD_LEN-1:0] divisor_q;
  logic [WORD_LEN:0]   divisor_mag;
  logic [WORD_LEN-1:0] part_rem;
  logic [WORD_LEN-1:0] quo;
  logic [WORD_LEN-1:0] dividend_abs;
  logic [WORD_LEN-1:0] divisor_abs;
  logic [WORD_LEN:0]   trial;
  logic [WORD_LEN+1:0] diff;
  logic                is_overflow;

  // The most-negative value negates to itself, which read as unsigned is its true magnitude.
  always_comb begin
    dividend_abs = i_dividend[WORD_LEN-1] ? -i_dividend : i_dividend;
    divisor_abs  = i_divisor[WORD_LEN-1]  ? -i_divisor  : i_divisor;
    trial        = {part_rem, quo[WORD_LEN-1]};
    diff         = {1'b0, trial} - {1'b0, divisor_mag};
    is_overflow  = (dividend_q == {1'b1, {(WORD_LEN-1){1'b0}}}) && (divisor_q == '1);
  end

  // quo starts as |dividend| and shifts out its MSBs while quotient bits shift in at the LSB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      count         <= '0;
      dividend_q    <= '0;
      divisor_q     <= '0;
      divisor_mag   <= '0;
      part_rem      <= '0;
      quo           <= '0;
      o_ready       <= 1'b1;
      o_valid       <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            dividend_q <= i_dividend;
            divisor_q  <= i_divisor;
            o_ready    <= 1'b0;
            if (i_divisor == '0) begin
              state         <= DONE;
              o_valid       <= 1'b1;
              o_quotient    <= '1;
              o_remainder   <= i_dividend;
              o_div_by_zero <= 1'b1;
              o_overflow    <= 1'b0;
            end else begin
              state       <= CALC;
              quo         <= dividend_abs;
              part_rem    <= '0;
              divisor_mag <= {1'b0, divisor_abs};
              count       <= '0;
            end
          end
        end
        CALC: begin
          // A clear borrow bit means the trial subtraction fits: keep it and emit a 1.
          if (!diff[WORD_LEN+1]) begin
            part_rem <= diff[WORD_LEN-1:0];
            quo      <= {quo[WORD_LEN-2:0], 1'b1};
          end else begin
            part_rem <= trial[WORD_LEN-1:0];
            quo      <= {quo[WORD_LEN-2:0], 1'b0};
          end
          if (count == CW'(WORD_LEN-1)) begin
            count <= '0;
            state <= FIX;
          end else begin
            count <= count + CW'(1);
          end
        end
        FIX: begin
          o_quotient    <= (dividend_q[WORD_LEN-1] ^ divisor_q[WORD_LEN-1]) ? -quo : quo;
          o_remainder   <= dividend_q[WORD_LEN-1] ? -part_rem : part_rem;
          o_div_by_zero <= 1'b0;
          o_overflow    <= is_overflow;
          o_valid       <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
